// File: rtl/usr_pkg.sv
// Mode encodings and sizing helper shared by the universal shift register
// and its shift counter.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Bits needed to hold 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_counter.sv
// Saturating shift counter: counts shifts up to WIDTH and pulses Done on the
// edge where the count first reaches WIDTH.
module shift_counter
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          clear,
    input  logic                          inc,
    output logic [cnt_width(WIDTH)-1:0]   Cnt,
    output logic                          Done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (inc && (r_cnt < CNT_MAX)) begin
            r_cnt  <= r_cnt + 1'b1;
            r_done <= (r_cnt == CNT_LAST);
        end else begin
            // Saturated shifts and idle cycles both drop the pulse.
            r_done <= 1'b0;
        end
    end

    assign Cnt  = r_cnt;
    assign Done = r_done;

endmodule

// File: rtl/universal_shift_register.sv
// Parametrised hold / shift-right / shift-left / parallel-load register with
// optional rotate, clock enable and a word-complete shift counter.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ROTATE = 0,
    parameter int CNT_W  = cnt_width(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] Pi,
    input  logic             Sin_R,
    input  logic             Sin_L,
    output logic [WIDTH-1:0] Po,
    output logic             Sout_R,
    output logic             Sout_L,
    output logic [CNT_W-1:0] Cnt,
    output logic             Done
);

    logic [WIDTH-1:0] r_po;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;
    logic             w_in_r;
    logic             w_in_l;
    logic             w_clear;
    logic             w_inc;

    // In rotate mode the bit falling off one end re-enters at the other.
    assign w_in_r = (ROTATE != 0) ? r_po[0]       : Sin_R;
    assign w_in_l = (ROTATE != 0) ? r_po[WIDTH-1] : Sin_L;

    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shr = w_in_r;
            assign w_shl = w_in_l;
        end else begin : g_wn
            assign w_shr = {w_in_r, r_po[WIDTH-1:1]};
            assign w_shl = {r_po[WIDTH-2:0], w_in_l};
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_po <= '0;
        end else if (En) begin
            case (Mode)
                MODE_SHR:  r_po <= w_shr;
                MODE_SHL:  r_po <= w_shl;
                MODE_LOAD: r_po <= Pi;
                default:   r_po <= r_po;
            endcase
        end
    end

    assign w_clear = En && (Mode == MODE_LOAD);
    assign w_inc   = En && ((Mode == MODE_SHR) || (Mode == MODE_SHL));

    shift_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .clear (w_clear),
        .inc   (w_inc),
        .Cnt   (Cnt),
        .Done  (Done)
    );

    assign Po     = r_po;
    assign Sout_R = r_po[0];
    assign Sout_L = r_po[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench: a shift-pass and a rotate instance share stimulus; expected
// state from an arithmetic reference model is queued and checked per cycle.
module tb_universal_shift_register;

    localparam int W = 8;

    typedef struct {
        logic [7:0] po;
        logic [7:0] pr;
        logic [3:0] cnt;
        logic       done;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       En = 1'b0;
    logic [1:0] Mode = 2'b00;
    logic [7:0] Pi = 8'h00;
    logic       Sin_R = 1'b0;
    logic       Sin_L = 1'b0;

    logic [7:0] po_s, po_r;
    logic       sr_s, sl_s, sr_r, sl_r;
    logic [3:0] cnt_s, cnt_r;
    logic       done_s, done_r;

    int errors = 0;
    int checks = 0;

    exp_t q[$];
    int   m_po = 0, m_pr = 0, m_cnt = 0;
    bit   m_done = 0;

    always #5 Clk = ~Clk;

    universal_shift_register #(.WIDTH(W), .ROTATE(0)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .Pi(Pi),
        .Sin_R(Sin_R), .Sin_L(Sin_L), .Po(po_s), .Sout_R(sr_s),
        .Sout_L(sl_s), .Cnt(cnt_s), .Done(done_s)
    );

    universal_shift_register #(.WIDTH(W), .ROTATE(1)) dut_rot (
        .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .Pi(Pi),
        .Sin_R(Sin_R), .Sin_L(Sin_L), .Po(po_r), .Sout_R(sr_r),
        .Sout_L(sl_r), .Cnt(cnt_r), .Done(done_r)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the edge.
    task automatic step(input bit rst, input bit en, input logic [1:0] mode,
                        input logic [7:0] pi, input bit sr, input bit sl);
        exp_t e;
        bit   shift;
        @(negedge Clk);
        Rst = rst; En = en; Mode = mode; Pi = pi; Sin_R = sr; Sin_L = sl;
        shift = 0;
        if (rst) begin
            m_po = 0; m_pr = 0; m_cnt = 0; m_done = 0;
        end else if (!en || mode == 2'd0) begin
            m_done = 0;
        end else if (mode == 2'd3) begin
            m_po = pi; m_pr = pi; m_cnt = 0; m_done = 0;
        end else if (mode == 2'd1) begin
            m_po = (m_po >> 1) | (int'(sr) << (W - 1));
            m_pr = (m_pr >> 1) | ((m_pr & 1) << (W - 1));
            shift = 1;
        end else begin
            m_po = ((m_po << 1) & 8'hFF) | int'(sl);
            m_pr = ((m_pr << 1) & 8'hFF) | (m_pr >> (W - 1));
            shift = 1;
        end
        if (shift) begin
            if (m_cnt < W) begin
                m_cnt++;
                m_done = (m_cnt == W);
            end else begin
                m_done = 0;
            end
        end
        e.po = 8'(m_po); e.pr = 8'(m_pr); e.cnt = 4'(m_cnt); e.done = m_done;
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge Clk);
        #2;
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("po",     32'(po_s),   32'(e.po));
                chk("sout_r", 32'(sr_s),   32'(e.po[0]));
                chk("sout_l", 32'(sl_s),   32'(e.po[7]));
                chk("cnt",    32'(cnt_s),  32'(e.cnt));
                chk("done",   32'(done_s), 32'(e.done));
                chk("po_rot", 32'(po_r),   32'(e.pr));
                chk("sr_rot", 32'(sr_r),   32'(e.pr[0]));
                chk("sl_rot", 32'(sl_r),   32'(e.pr[7]));
                chk("cnt_rot",  32'(cnt_r),  32'(e.cnt));
                chk("done_rot", 32'(done_r), 32'(e.done));
            end
        end
    end

    initial begin
        logic [7:0] sipo_bits;
        int         wait_cyc;
        int         done_seen;

        // Reset overrides load.
        step(1, 1, 2'b11, 8'hFF, 0, 0);
        step(1, 1, 2'b11, 8'hFF, 0, 0);
        settle();
        chk("rst_po", 32'(po_s), 32'h00);
        chk("rst_cnt", 32'(cnt_s), 32'h0);
        chk("rst_done", 32'(done_s), 32'h0);
        step(0, 1, 2'b11, 8'hFF, 0, 0);
        settle();
        chk("rel_po", 32'(po_s), 32'hFF);

        // PISO: right shifts of A5.
        step(0, 1, 2'b11, 8'hA5, 0, 0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2'b01, 8'h00, 0, 0);
            settle();
            done_seen += int'(done_s);
        end
        chk("piso_po", 32'(po_s), 32'h00);
        chk("piso_cnt", 32'(cnt_s), 32'd8);
        chk("piso_done_cnt", 32'(done_seen), 32'd1);

        // SIPO: left shifts build CA.
        sipo_bits = 8'b11001010;
        step(0, 1, 2'b11, 8'h00, 0, 0);
        for (int i = 7; i >= 0; i--) step(0, 1, 2'b10, 8'h00, 0, sipo_bits[i]);
        settle();
        chk("sipo_po", 32'(po_s), 32'hCA);
        step(0, 1, 2'b10, 8'h00, 0, 0);
        settle();
        chk("sipo_sat_cnt", 32'(cnt_s), 32'd8);
        chk("sipo_sat_done", 32'(done_s), 32'd0);

        // Rotate with serial inputs toggling.
        step(0, 1, 2'b11, 8'h81, 0, 0);
        step(0, 1, 2'b01, 8'h00, 1, 0);
        settle();
        chk("rot_r1", 32'(po_r), 32'hC0);
        step(0, 1, 2'b10, 8'h00, 0, 1);
        step(0, 1, 2'b10, 8'h00, 1, 0);
        settle();
        chk("rot_l2", 32'(po_r), 32'h03);

        // Enable low and hold mode keep state.
        step(0, 1, 2'b11, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b01, 8'h00, 1, 1);
        step(0, 1, 2'b00, 8'hFF, 1, 1);
        settle();
        chk("hold_po", 32'(po_s), 32'h3C);
        chk("hold_cnt", 32'(cnt_s), 32'd0);

        // Reload mid-word restarts the count.
        step(0, 1, 2'b11, 8'hF0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 2'b01, 8'h00, 1, 0);
        step(0, 1, 2'b11, 8'h0F, 0, 0);
        settle();
        chk("reload_po", 32'(po_s), 32'h0F);
        chk("reload_cnt", 32'(cnt_s), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, (i % 2 == 0) ? 2'b01 : 2'b10, 8'h00, 1, 0);
            settle();
            done_seen += int'(done_s);
        end
        chk("reload_done_cnt", 32'(done_seen), 32'd1);

        // Reset mid-word aborts the word.
        step(0, 1, 2'b11, 8'h55, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 2'b10, 8'h00, 0, 1);
        step(1, 1, 2'b01, 8'h00, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 0);
        settle();
        chk("abort_done", 32'(done_s), 32'd0);
        chk("abort_cnt", 32'(cnt_s), 32'd1);

        // Randomised traffic, loads kept rare so words complete.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] md;
            md = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) md = 2'b11;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), md,
                 8'($urandom), 1'($urandom), 1'($urandom));
        end

        wait_cyc = 0;
        while (q.size() != 0 && wait_cyc < 20) begin
            @(posedge Clk);
            wait_cyc++;
        end
        #3;
        chk("drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the fixed 4-bit parallel-in/parallel-out register.
- Adds the following on top of synchronous parallel load:
  - width parameter
  - clock enable
  - bidirectional shift with serial in/out
  - optional rotate mode
  - shift counter with a word-complete strobe
- Serves as the common register primitive for serialiser (PISO), deserialiser (SIPO), PIPO and ring-shift uses in lab designs.

Parameters:
- WIDTH, 8, register width in bits; legal range ≥1.
- ROTATE, 0, 1 = shifts rotate the register contents and ignore serial inputs; 0 = shifts take serial inputs.
- CNT_W, $clog2(WIDTH+1), width of shift counter; derived, do not override.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous reset, active-high.
- En  input  1  clock enable; 0 = all state held.
- Mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- Pi  input  WIDTH  parallel data in.
- Sin_R  input  1  serial in for shift right; enters the MSB.
- Sin_L  input  1  serial in for shift left; enters the LSB.
- Po  output  WIDTH  registered parallel out.
- Sout_R  output  1  Po[0]; bit leaving on a right shift.
- Sout_L  output  1  Po[WIDTH-1]; bit leaving on a left shift.
- Cnt  output  CNT_W  shifts performed since last load or reset; saturates at WIDTH.
- Done  output  1  one-cycle pulse on the edge where Cnt reaches WIDTH.

Behaviour:
- Reset, sampled at posedge Clk when Rst=1: Po=0, Cnt=0, Done=0. Reset overrides En and Mode.
- All register updates occur at posedge Clk only. Po, Cnt and Done are registered; Sout_R and Sout_L are combinational taps of Po.
- Latency: changes to Pi or Mode appear on Po one clock after the edge at which they are sampled.
- En=0: Po and Cnt hold; Done=0.
- En=1, Mode=00: hold; Done=0.
- En=1, Mode=11: Po<=Pi; Cnt<=0; Done=0.
- En=1, Mode=01: Po<={Sin_R, Po[WIDTH-1:1]}. With ROTATE=1, Sin_R is replaced by Po[0].
- En=1, Mode=10: Po<={Po[WIDTH-2:0], Sin_L}. With ROTATE=1, Sin_L is replaced by Po[WIDTH-1].
- Counter on a shift:
  - If Cnt<WIDTH: Cnt<=Cnt+1. Done<=1 only when Cnt==WIDTH-1, otherwise 0.
  - If Cnt==WIDTH: Cnt holds (saturates) and Done<=0. Shifting continues normally.
- Direction changes mid-word do not reset Cnt; both directions count.
- WIDTH=1: left and right shifts both load the serial bit; rotate is a no-op on data. Done pulses on the first shift after load or reset.
- Mode values are fully decoded; no illegal states.
- Rst asserted mid-word aborts the word: Cnt=0, and Done is not issued.

Decomposition:
- Shared package usr_pkg:
  - Mode localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
  - Counter width function.
- One natural sub-module: shift_counter (parameter WIDTH).
  - Inputs: Clk, Rst, clear, inc.
  - Outputs: Cnt, Done.
  - Owns the saturation and pulse logic.
- The top level holds the data register and mux.

Test Plan:
- Reset: drive Rst=1 for 2 cycles with Mode=11, Pi=8'hFF, En=1 → Po=8'h00, Cnt=0, Done=0. Release Rst → next edge Po=8'hFF.
- PISO: load 8'hA5, then 8 right shifts with Sin_R=0 → Sout_R sequence 1,0,1,0,0,1,0,1. Cnt counts 1..8. Done high only on the 8th edge. Po=8'h00 after.
- SIPO: load 0, then shift left with Sin_L sequence 1,1,0,0,1,0,1,0 → Po=8'hCA. Done pulses once. A 9th shift leaves Cnt=8 and Done=0.
- Rotate (ROTATE=1): load 8'h81, shift right 1 → Po=8'hC0; shift left 2 → Po=8'h03; Sin inputs toggled throughout have no effect.
- Enable/hold: load 8'h3C, shift right with En=0 for 3 cycles, then Mode=00 with En=1 → Po stays 8'h3C, Cnt stays 0.
- Reload mid-word: load 8'hF0, 5 right shifts, load 8'h0F → Cnt=0, Po=8'h0F, no Done; 8 further shifts → single Done.
